// File: rtl/ml_sweep_ctrl.sv
// ml_sweep_ctrl: sequencer for the 4x4 QPSK ML hard-decision detector.
// Accepts one (y_hat, R) pair, holds it on the detector inputs while it sweeps
// all 64 candidates, waits (bounded by LAT_MAX) for the detector result and
// presents the hard decision downstream over a valid/ready handshake.
// Optional feature: define ML_SWEEP_PREFETCH_EN to add a one-entry pending
// buffer so the next vector can be accepted while the current one is in flight.
module ml_sweep_ctrl #(
    parameter int DATA_WIDTH = 20,
    parameter int LAT_MAX    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [8*DATA_WIDTH-1:0]  i_y_hat,
    input  logic [16*DATA_WIDTH-1:0] i_r,
    output logic                     o_ml_enable,
    output logic [5:0]               o_ml_cnt,
    output logic [8*DATA_WIDTH-1:0]  o_ml_y_hat,
    output logic [16*DATA_WIDTH-1:0] o_ml_r,
    input  logic                     i_ml_valid,
    input  logic [7:0]               i_ml_hardbit,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [7:0]               o_out_hardbit,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int YW = 8 * DATA_WIDTH;
    localparam int RW = 16 * DATA_WIDTH;
    localparam int TW = $clog2(LAT_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'(LAT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    cnt;
    logic [TW-1:0] tmo;
    logic [YW-1:0] y_act;
    logic [RW-1:0] r_act;
    logic [7:0]    hard;
    logic          err;

    logic          in_fire;
    logic          load_act;
    logic          take_res;
    logic          take_tmo;
    logic [YW-1:0] next_y;
    logic [RW-1:0] next_r;

`ifdef ML_SWEEP_PREFETCH_EN
    logic          pend_full;
    logic [YW-1:0] pend_y;
    logic [RW-1:0] pend_r;

    // Any vector accepted outside IDLE parks here unless it loads the active regs directly.
    assign o_in_ready = (state == S_IDLE) | ~pend_full;
    assign next_y     = pend_full ? pend_y : i_y_hat;
    assign next_r     = pend_full ? pend_r : i_r;

    // Pending-buffer occupancy: set on a parked accept, cleared when the OUT handshake consumes it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_full <= 1'b0;
        end else if (state == S_OUT && i_out_ready && pend_full) begin
            pend_full <= 1'b0;
        end else if (in_fire && !load_act) begin
            pend_full <= 1'b1;
        end
    end

    // Pending payload capture.
    // NOTE: the payload has no reset; pend_full alone says whether it is meaningful.
    always_ff @(posedge i_clk) begin
        if (in_fire && !load_act) begin
            pend_y <= i_y_hat;
            pend_r <= i_r;
        end
    end
`else
    logic pend_full;

    // Without a buffer the next vector is only taken in the same cycle the result leaves.
    assign pend_full  = 1'b0;
    assign o_in_ready = (state == S_IDLE) | ((state == S_OUT) & i_out_ready);
    assign next_y     = i_y_hat;
    assign next_r     = i_r;
`endif

    assign in_fire = i_in_valid & o_in_ready;

    // Next-state and load decisions for the IDLE/SWEEP/DRAIN/OUT sequence.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load_act  = 1'b0;
        take_res  = 1'b0;
        take_tmo  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_fire) begin
                    load_act  = 1'b1;
                    state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (cnt == 6'd63) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A result arriving on the timeout cycle still wins.
                if (i_ml_valid) begin
                    take_res  = 1'b1;
                    state_nxt = S_OUT;
                end else if (tmo == TMO_LAST) begin
                    take_tmo  = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    if (pend_full || in_fire) begin
                        load_act  = 1'b1;
                        state_nxt = S_SWEEP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Candidate counter: cleared on load, free-running through SWEEP, parked at 63 afterwards.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (load_act) begin
            cnt <= '0;
        end else if (state == S_SWEEP && cnt != 6'd63) begin
            cnt <= cnt + 6'd1;
        end
    end

    // DRAIN timeout counter: counts DRAIN cycles, held at zero everywhere else.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo <= '0;
        end else if (state == S_DRAIN) begin
            tmo <= tmo + 1'b1;
        end else begin
            tmo <= '0;
        end
    end

    // Active operand registers: change only when a new detection is loaded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            y_act <= '0;
            r_act <= '0;
        end else if (load_act) begin
            y_act <= next_y;
            r_act <= next_r;
        end
    end

    // Hard-decision register and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hard <= '0;
            err  <= 1'b0;
        end else if (take_res) begin
            hard <= i_ml_hardbit;
        end else if (take_tmo) begin
            hard <= 8'h00;
            err  <= 1'b1;
        end
    end

    assign o_ml_enable   = (state == S_SWEEP);
    assign o_ml_cnt      = cnt;
    assign o_ml_y_hat    = y_act;
    assign o_ml_r        = r_act;
    assign o_out_valid   = (state == S_OUT);
    assign o_out_hardbit = hard;
    assign o_busy        = (state != S_IDLE);
    assign o_err         = err;

endmodule
